arr_wavefront_sequencer: RTL and testbench

- Synthesizable generator of the skewed per-column buffer-empty wavefront and the one-hot gbus read-valid sweep for the PE array.
- Replaces hand-timed stimulus with a parametrised, cycle-exact engine.
- Sits beside the controller, driven by its abuf k-compute read-address increment.
- Adds runtime-configurable gap and repeat count, a row mask, abort, and trigger-drop reporting.

---
 rtl/arr_wavefront_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_arr_wavefront_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/arr_wavefront_sequencer.sv
// Skewed buffer-empty wavefront plus one-hot gbus read-valid sweep for the PE array.
// A kcompute_inc rising edge launches a run of cfg_reps column sweeps spaced cfg_gap cycles apart.
module arr_wfs_row #(
  parameter int VNUM = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [VNUM-1:0] col_empty,
  input  logic            row_en,
  input  logic            pulse_en,
  input  logic [VNUM-1:0] col_oh,
  output logic [VNUM-1:0] empty,
  output logic [VNUM-1:0] rvalid
);
  assign empty = col_empty | {VNUM{~row_en}};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rvalid <= '0;
    else       rvalid <= pulse_en ? col_oh : '0;
  end
endmodule

module arr_wavefront_sequencer #(
  parameter int HNUM      = 8,
  parameter int VNUM      = 8,
  parameter int SKEW      = 1,
  parameter int START_DLY = 8,
  parameter int GAP_W     = 4,
  parameter int REP_W     = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 kcompute_inc,
  input  logic [GAP_W-1:0]     cfg_gap,
  input  logic [REP_W-1:0]     cfg_reps,
  input  logic [HNUM-1:0]      row_mask,
  input  logic                 abort,
  output logic [HNUM*VNUM-1:0] abuf_empty,
  output logic [HNUM*VNUM-1:0] lbuf_empty,
  output logic [HNUM*VNUM-1:0] gbus_rvalid,
  output logic                 busy,
  output logic                 done,
  output logic                 trig_drop
);
  localparam int CW    = (VNUM > 1) ? $clog2(VNUM) : 1;
  localparam int DW    = $clog2(START_DLY + 1);
  localparam int CHAIN = 1 + (VNUM - 1) * SKEW;

  typedef enum logic [2:0] {IDLE, DELAY, PULSE, GAP, DONE} state_t;

  typedef struct packed {
    logic [GAP_W-1:0] gap;
    logic [REP_W-1:0] reps;
    logic [HNUM-1:0]  mask;
  } cfg_t;

  // Empty wavefront: one shift chain shared by all rows, tapped every SKEW stages.
  logic [CHAIN-1:0] chain;
  logic [VNUM-1:0]  col_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) chain <= '1;
    else begin
      chain[0] <= ~kcompute_inc;
      for (int i = 1; i < CHAIN; i++) chain[i] <= chain[i-1];
    end
  end

  for (genvar v = 0; v < VNUM; v++) begin : g_tap
    assign col_empty[v] = chain[v*SKEW];
  end

  logic kc_q, trig;
  assign trig = kcompute_inc & ~kc_q;

  state_t           state, state_nxt;
  logic [DW-1:0]    dly, dly_nxt;
  logic [GAP_W-1:0] gcnt, gcnt_nxt;
  logic [CW-1:0]    col, col_nxt;
  logic [REP_W-1:0] rep, rep_nxt;
  cfg_t             cfg, cfg_nxt;
  logic [GAP_W-1:0] gap_eff;
  logic [REP_W-1:0] reps_eff;
  logic             adv;

  assign gap_eff  = (cfg.gap <= GAP_W'(1)) ? GAP_W'(1) : cfg.gap;
  assign reps_eff = (cfg.reps == '0) ? REP_W'(1) : cfg.reps;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      kc_q  <= 1'b0;
      state <= IDLE;
      dly   <= '0;
      gcnt  <= '0;
      col   <= '0;
      rep   <= '0;
      cfg   <= '0;
    end else begin
      kc_q  <= kcompute_inc;
      state <= state_nxt;
      dly   <= dly_nxt;
      gcnt  <= gcnt_nxt;
      col   <= col_nxt;
      rep   <= rep_nxt;
      cfg   <= cfg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dly_nxt   = dly;
    gcnt_nxt  = gcnt;
    col_nxt   = col;
    rep_nxt   = rep;
    cfg_nxt   = cfg;
    adv       = 1'b0;
    unique case (state)
      IDLE: if (trig && !abort) begin
        cfg_nxt.gap  = cfg_gap;
        cfg_nxt.reps = cfg_reps;
        cfg_nxt.mask = row_mask;
        col_nxt      = '0;
        rep_nxt      = '0;
        if (START_DLY == 1) state_nxt = PULSE;
        else begin
          state_nxt = DELAY;
          dly_nxt   = DW'(START_DLY - 1);
        end
      end
      // Leave on the cycle the counter would reach zero so the first pulse lands START_DLY after trig.
      DELAY: if (dly <= DW'(1)) begin
        state_nxt = PULSE;
        dly_nxt   = '0;
        col_nxt   = '0;
        rep_nxt   = '0;
      end else dly_nxt = dly - 1'b1;
      PULSE: if (gap_eff > GAP_W'(1)) begin
        state_nxt = GAP;
        gcnt_nxt  = gap_eff - GAP_W'(2);
      end else adv = 1'b1;
      GAP: if (gcnt == '0) adv = 1'b1;
           else gcnt_nxt = gcnt - 1'b1;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (adv) begin
      if (col != CW'(VNUM - 1)) begin
        col_nxt   = col + 1'b1;
        state_nxt = PULSE;
      end else if (rep != reps_eff - 1'b1) begin
        col_nxt   = '0;
        rep_nxt   = rep + 1'b1;
        state_nxt = PULSE;
      end else state_nxt = DONE;
    end
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      trig_drop <= 1'b0;
    end else begin
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      trig_drop <= trig && (state != IDLE);
    end
  end

  logic [VNUM-1:0]            col_oh;
  logic [HNUM-1:0][VNUM-1:0]  empty_pk, rv_pk;

  assign col_oh = (state_nxt == PULSE) ? (VNUM'(1) << col_nxt) : '0;

  for (genvar h = 0; h < HNUM; h++) begin : g_row
    arr_wfs_row #(.VNUM(VNUM)) u_row (
      .clk       (clk),
      .rstn      (rstn),
      .col_empty (col_empty),
      .row_en    (row_mask[h]),
      .pulse_en  (cfg_nxt.mask[h]),
      .col_oh    (col_oh),
      .empty     (empty_pk[h]),
      .rvalid    (rv_pk[h])
    );
  end

  assign abuf_empty  = empty_pk;
  assign lbuf_empty  = empty_pk;
  assign gbus_rvalid = rv_pk;
endmodule

// File: tb/tb_arr_wavefront_sequencer.sv
// Directed bench: stimulus pushes expected rvalid/done/trig_drop events, a negedge monitor pops and checks them.
module tb_arr_wavefront_sequencer;
  logic        clk = 1'b0;
  logic        rstn;
  logic        kcompute_inc;
  logic [3:0]  cfg_gap;
  logic [4:0]  cfg_reps;
  logic [7:0]  row_mask;
  logic        abort;
  logic [63:0] abuf_empty, lbuf_empty, gbus_rvalid;
  logic        busy, done, trig_drop;

  arr_wavefront_sequencer dut (
    .clk(clk), .rstn(rstn), .kcompute_inc(kcompute_inc), .cfg_gap(cfg_gap),
    .cfg_reps(cfg_reps), .row_mask(row_mask), .abort(abort),
    .abuf_empty(abuf_empty), .lbuf_empty(lbuf_empty), .gbus_rvalid(gbus_rvalid),
    .busy(busy), .done(done), .trig_drop(trig_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [63:0] val;
  } rv_ev_t;

  rv_ev_t rv_q[$];
  int     done_q[$];
  int     drop_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rv_exp(input int c, input logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int h = 0; h < 8; h++) if (m[h]) r[h*8+c] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] exp_empty(input logic [7:0] colz, input logic [7:0] m);
    logic [63:0] r;
    for (int h = 0; h < 8; h++)
      for (int v = 0; v < 8; v++) r[h*8+v] = !(m[h] && colz[v]);
    return r;
  endfunction

  task automatic push_run(input int t, input int g, input int r, input logic [7:0] m, input int lim);
    int ge, re, tot, l;
    ge  = (g <= 1) ? 1 : g;
    re  = (r == 0) ? 1 : r;
    tot = 8 * re;
    l   = (lim < 0) ? tot : lim;
    for (int k = 0; k < tot; k++)
      if (k < l) rv_q.push_back('{t + 8 + ge * k, rv_exp(k % 8, m)});
    if (l >= tot) done_q.push_back(t + 8 + ge * tot);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_kc(output int t);
    kcompute_inc = 1'b1;
    t = cyc;
    tick();
    kcompute_inc = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((rv_q.size() + done_q.size() + drop_q.size()) != 0 && n < 1000) begin
      tick();
      n++;
    end
    chk(nm, 64'(rv_q.size() + done_q.size() + drop_q.size()), 64'd0);
    rv_q.delete(); done_q.delete(); drop_q.delete();
    tick(10);
  endtask

  // Monitor
  always @(negedge clk) begin
    rv_ev_t e;
    int     c;
    if (rstn) begin
      if (gbus_rvalid != '0) begin
        if (rv_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rv_unexpected: got %h expected none (cycle %0d)", gbus_rvalid, cyc);
        end else begin
          e = rv_q.pop_front();
          chk("rv_cycle", 64'(cyc), 64'(e.cyc));
          chk("rv_value", gbus_rvalid, e.val);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          c = done_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(c));
        end
      end
      if (trig_drop) begin
        if (drop_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL drop_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          c = drop_q.pop_front();
          chk("drop_cycle", 64'(cyc), 64'(c));
        end
      end
    end
  end

  initial begin
    int t, a;
    logic [7:0] colz;
    rstn = 1'b0; kcompute_inc = 1'b0; abort = 1'b0;
    cfg_gap = 4'd4; cfg_reps = 5'd1; row_mask = 8'hff;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_abuf", abuf_empty, '1);
    chk("rst_lbuf", lbuf_empty, '1);
    chk("rst_rvalid", gbus_rvalid, '0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_drop", 64'(trig_drop), 64'd0);
    rstn = 1'b1;
    tick(5);

    // Reset in the middle of a run, during the column-3 pulse
    pulse_kc(t);
    push_run(t, 4, 1, 8'hff, 3);
    tick(19);
    rstn = 1'b0;
    #1;
    chk("midrst_rvalid", gbus_rvalid, '0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_abuf", abuf_empty, '1);
    tick(2);
    rstn = 1'b1;
    tick(20);
    chk("midrst_idle_busy", 64'(busy), 64'd0);
    drain("midrst_drain");

    // Default-style long run: gap 4, 12 sweeps
    cfg_gap = 4'd4; cfg_reps = 5'd12; row_mask = 8'hff;
    pulse_kc(t);
    push_run(t, 4, 12, 8'hff, -1);
    chk("busy_start", 64'(busy), 64'd1);
    tick(391);
    chk("busy_in_done", 64'(busy), 64'd1);
    tick();
    chk("busy_after_done", 64'(busy), 64'd0);
    drain("long_drain");

    // Empty wavefront with kcompute_inc held for 5 cycles
    cfg_gap = 4'd1; cfg_reps = 5'd1; row_mask = 8'hff;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin
        t = cyc;
        push_run(t, 1, 1, 8'hff, -1);
      end
      kcompute_inc = (i < 5);
      for (int v = 0; v < 8; v++) colz[v] = (i >= 1 + v) && (i <= 5 + v);
      chk("wave_abuf", abuf_empty, exp_empty(colz, 8'hff));
      chk("wave_lbuf", lbuf_empty, exp_empty(colz, 8'hff));
      tick();
    end
    kcompute_inc = 1'b0;
    drain("wave_drain");

    // Gap 0 / reps 0 treated as 1, rows 0 and 2 only
    cfg_gap = 4'd0; cfg_reps = 5'd0; row_mask = 8'b0000_0101;
    kcompute_inc = 1'b1;
    t = cyc;
    push_run(t, 0, 0, 8'b0000_0101, -1);
    tick();
    chk("mask_abuf", abuf_empty, exp_empty(8'h01, 8'b0000_0101));
    chk("mask_lbuf", lbuf_empty, exp_empty(8'h01, 8'b0000_0101));
    kcompute_inc = 1'b0;
    drain("mask_drain");

    // Second trigger edge during a GAP is dropped
    cfg_gap = 4'd4; cfg_reps = 5'd1; row_mask = 8'hff;
    pulse_kc(t);
    push_run(t, 4, 1, 8'hff, -1);
    tick(8);
    kcompute_inc = 1'b1;
    drop_q.push_back(t + 10);
    tick();
    kcompute_inc = 1'b0;
    drain("drop_drain");

    // Abort during the second sweep, then a fresh run
    cfg_gap = 4'd2; cfg_reps = 5'd3; row_mask = 8'hff;
    pulse_kc(t);
    push_run(t, 2, 3, 8'hff, 12);
    tick(29);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rvalid", gbus_rvalid, '0);
    cfg_gap = 4'd1; cfg_reps = 5'd1;
    tick();
    pulse_kc(a);
    push_run(a, 1, 1, 8'hff, -1);
    drain("abort_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
